// File: rtl/d2e_pipe_reg.sv
// D-to-E pipeline register: latches decoded D fields, inserts bubbles on Stall, flushes to the handler on Req.
// Build option D2E_BUBBLE_KEEP_PC_EN: a bubble keeps the stalled instruction's PC and BD (macroscopic PC).
module d2e_pipe_reg #(
   parameter logic [31:0] RESET_PC   = 32'h0000_3000,
   parameter logic [31:0] HANDLER_PC = 32'h0000_4180
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        Stall,
   input  logic        Req,
   input  logic [31:0] DPC,
   input  logic [31:0] DInstr,
   input  logic [31:0] DRD1,
   input  logic [31:0] DRD2,
   input  logic [31:0] DExt,
   input  logic [4:0]  DRegDst,
   input  logic        DWriteRegEn,
   input  logic [2:0]  DTNew,
   input  logic        DWriteEPC,
   input  logic [4:0]  DExcCode,
   input  logic        DBD,
   output logic [31:0] EPC,
   output logic [31:0] EInstr,
   output logic [31:0] ERD1,
   output logic [31:0] ERD2,
   output logic [31:0] EExt,
   output logic [4:0]  ERegDst,
   output logic        EWriteRegEn,
   output logic [2:0]  ETNew,
   output logic        EWriteEPC,
   output logic [4:0]  EExcCode,
   output logic        EBD,
   output logic [2:0]  EMTNew
);

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         EPC         <= RESET_PC;
         EInstr      <= '0;
         ERD1        <= '0;
         ERD2        <= '0;
         EExt        <= '0;
         ERegDst     <= '0;
         EWriteRegEn <= 1'b0;
         ETNew       <= '0;
         EWriteEPC   <= 1'b0;
         EExcCode    <= '0;
         EBD         <= 1'b0;
      end else if (Req) begin
         // Flush wins over Stall: the handler's first fetch must not see a held instruction.
         EPC         <= HANDLER_PC;
         EInstr      <= '0;
         ERD1        <= '0;
         ERD2        <= '0;
         EExt        <= '0;
         ERegDst     <= '0;
         EWriteRegEn <= 1'b0;
         ETNew       <= '0;
         EWriteEPC   <= 1'b0;
         EExcCode    <= '0;
         EBD         <= 1'b0;
      end else if (Stall) begin
         EInstr      <= '0;
         ERD1        <= '0;
         ERD2        <= '0;
         EExt        <= '0;
         ERegDst     <= '0;
         EWriteRegEn <= 1'b0;
         ETNew       <= '0;
         EWriteEPC   <= 1'b0;
         EExcCode    <= '0;
`ifdef D2E_BUBBLE_KEEP_PC_EN
         EPC         <= DPC;
         EBD         <= DBD;
`else
         EPC         <= '0;
         EBD         <= 1'b0;
`endif
      end else begin
         EPC         <= DPC;
         EInstr      <= DInstr;
         ERD1        <= DRD1;
         ERD2        <= DRD2;
         EExt        <= DExt;
         ERegDst     <= DRegDst;
         EWriteRegEn <= DWriteRegEn;
         ETNew       <= DTNew;
         EWriteEPC   <= DWriteEPC;
         EExcCode    <= DExcCode;
         EBD         <= DBD;
      end
   end

   // One stage closer to producing its result; never wraps below zero.
   assign EMTNew = (ETNew == 3'd0) ? 3'd0 : ETNew - 3'd1;

endmodule
